// File: rtl/sopc_mem_arbiter_pkg.sv
// Shared types, sizing constants and helpers for the SOPC shared-memory arbiter.
package sopc_mem_arbiter_pkg;

  localparam int unsigned MAX_MASTERS = 8;
  localparam int unsigned IDX_W       = 3;
  localparam int unsigned CNT_W       = 4;

  localparam logic CHIP_ENABLE   = 1'b1;
  localparam logic CHIP_DISABLE  = 1'b0;
  localparam logic WRITE_DISABLE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  // Index of the set bit of a one-hot vector (zero when empty).
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < int'(MAX_MASTERS); i++) begin
      if (oh[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sopc_mem_arbiter_if.sv
// Bus bundle around the arbiter: master-side request lanes plus the memory port.
// The master modport is the environment (masters and memory); slave is the arbiter.
interface sopc_mem_arbiter_if #(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32
);

  logic [N_MASTERS-1:0]        m_req;
  logic [N_MASTERS-1:0]        m_we;
  logic [N_MASTERS*ADDR_W-1:0] m_addr;
  logic [N_MASTERS*DATA_W-1:0] m_wdata;
  logic [N_MASTERS-1:0]        m_ack;
  logic [DATA_W-1:0]           m_rdata;
  logic                        mem_ce;
  logic                        mem_we;
  logic [ADDR_W-1:0]           mem_addr;
  logic [DATA_W-1:0]           mem_wdata;
  logic [DATA_W-1:0]           mem_rdata;
  logic                        busy;

  modport master (
    output m_req, m_we, m_addr, m_wdata, mem_rdata,
    input  m_ack, m_rdata, mem_ce, mem_we, mem_addr, mem_wdata, busy
  );

  modport slave (
    input  m_req, m_we, m_addr, m_wdata, mem_rdata,
    output m_ack, m_rdata, mem_ce, mem_we, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/sopc_mem_arbiter_rr_picker.sv
// Combinational round-robin search: first requester after the last granted index.
module sopc_rr_picker
  import sopc_mem_arbiter_pkg::*;
#(
  parameter int unsigned N_MASTERS = 2
) (
  input  logic [N_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [N_MASTERS-1:0] grant_c,
  output logic                 valid_c
);

  logic [MAX_MASTERS-1:0] req_pad;
  logic [MAX_MASTERS-1:0] gnt_pad;
  logic [IDX_W-1:0]       idx;
  int                     sum;

  // Walk ptr+1 .. ptr+N (mod N) and take the first set request.
  always_comb begin
    req_pad = MAX_MASTERS'(req);
    gnt_pad = '0;
    valid_c = 1'b0;
    idx     = '0;
    sum     = 0;
    for (int k = 1; k <= int'(N_MASTERS); k++) begin
      sum = int'(ptr) + k;
      if (sum >= int'(N_MASTERS)) sum = sum - int'(N_MASTERS);
      idx = IDX_W'(sum);
      if (!valid_c && req_pad[idx]) begin
        gnt_pad[idx] = 1'b1;
        valid_c      = 1'b1;
      end
    end
    grant_c = gnt_pad[N_MASTERS-1:0];
  end

endmodule

// File: rtl/sopc_mem_arbiter.sv
// Shared instruction/data memory port: round-robin arbitration across N masters
// and fixed-latency issue to a single memory.
module sopc_mem_arbiter
  import sopc_mem_arbiter_pkg::*;
#(
  parameter int unsigned N_MASTERS   = 2,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input logic               clk,
  input logic               rst,
  sopc_mem_arbiter_if.slave bus
);

  state_t                 state;
  logic [IDX_W-1:0]       ptr;
  logic [N_MASTERS-1:0]   gnt_q;
  logic [CNT_W-1:0]       cnt;
  logic [N_MASTERS-1:0]   grant_c;
  logic                   valid_c;
  logic [IDX_W-1:0]       g_idx;
  logic [MAX_MASTERS-1:0] we_pad;
  logic [ADDR_W-1:0]      addr_arr  [MAX_MASTERS];
  logic [DATA_W-1:0]      wdata_arr [MAX_MASTERS];

  sopc_rr_picker #(.N_MASTERS(N_MASTERS)) u_picker (
    .req     (bus.m_req),
    .ptr     (ptr),
    .grant_c (grant_c),
    .valid_c (valid_c)
  );

  // Unpack the flattened master lanes so the winner can be selected by index.
  always_comb begin
    g_idx  = onehot_to_idx(MAX_MASTERS'(grant_c));
    we_pad = MAX_MASTERS'(bus.m_we);
    for (int i = 0; i < int'(MAX_MASTERS); i++) begin
      addr_arr[i]  = '0;
      wdata_arr[i] = '0;
    end
    for (int i = 0; i < int'(N_MASTERS); i++) begin
      addr_arr[i]  = bus.m_addr[i*ADDR_W +: ADDR_W];
      wdata_arr[i] = bus.m_wdata[i*DATA_W +: DATA_W];
    end
  end

  // Transaction FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      ptr           <= IDX_W'(N_MASTERS - 1);
      gnt_q         <= '0;
      cnt           <= '0;
      bus.m_ack     <= '0;
      bus.m_rdata   <= '0;
      bus.mem_ce    <= CHIP_DISABLE;
      bus.mem_we    <= WRITE_DISABLE;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (valid_c) begin
            state         <= ST_ISSUE;
            ptr           <= g_idx;
            gnt_q         <= grant_c;
            bus.mem_ce    <= CHIP_ENABLE;
            bus.mem_we    <= we_pad[g_idx];
            bus.mem_addr  <= addr_arr[g_idx];
            bus.mem_wdata <= wdata_arr[g_idx];
            bus.busy      <= 1'b1;
          end
        end
        ST_ISSUE: begin
          bus.mem_ce <= CHIP_DISABLE;
          cnt        <= CNT_W'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            state     <= ST_ACK;
            bus.m_ack <= gnt_q;
            if (bus.mem_we == WRITE_DISABLE) bus.m_rdata <= bus.mem_rdata;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state     <= ST_ACK;
            bus.m_ack <= gnt_q;
            if (bus.mem_we == WRITE_DISABLE) bus.m_rdata <= bus.mem_rdata;
          end
        end
        ST_ACK: begin
          state     <= ST_IDLE;
          bus.m_ack <= '0;
          bus.busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sopc_mem_arbiter.sv
// Scoreboard bench: DUT A (4 masters, no wait states) and DUT B (2 masters, 3 wait states).
module tb_sopc_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned NA = 4;
  localparam int unsigned WA = 0;
  localparam int unsigned NB = 2;
  localparam int unsigned WB = 3;

  typedef struct {
    int          cyc;
    logic [7:0]  ack;
    logic [31:0] rdata;
  } ack_exp_t;

  typedef struct {
    int          cyc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } iss_exp_t;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  ack_exp_t ack_qa[$];
  ack_exp_t ack_qb[$];
  iss_exp_t iss_qa[$];
  iss_exp_t iss_qb[$];
  ack_exp_t ae_a, ae_b;
  iss_exp_t ie_a, ie_b;

  logic [31:0] mem_a [logic [31:0]];
  logic [31:0] mem_b [logic [31:0]];
  int          pend_a = -100;
  int          pend_b = -100;
  logic [31:0] pend_addr_a;
  logic [31:0] pend_addr_b;

  sopc_mem_arbiter_if #(.N_MASTERS(NA), .ADDR_W(AW), .DATA_W(DW)) bus_a ();
  sopc_mem_arbiter_if #(.N_MASTERS(NB), .ADDR_W(AW), .DATA_W(DW)) bus_b ();

  sopc_mem_arbiter #(.N_MASTERS(NA), .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WA)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  sopc_mem_arbiter #(.N_MASTERS(NB), .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WB)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endfunction

  // Memory models: data is valid only in the cycle WAIT cycles after mem_ce.
  always @(negedge clk) begin
    if (bus_a.mem_ce === 1'b1) begin
      pend_a      = cyc;
      pend_addr_a = bus_a.mem_addr;
      if (bus_a.mem_we) mem_a[bus_a.mem_addr] = bus_a.mem_wdata;
    end
    if (cyc == pend_a + int'(WA))
      bus_a.mem_rdata = mem_a.exists(pend_addr_a) ? mem_a[pend_addr_a] : 32'h0;
    else
      bus_a.mem_rdata = 32'hBAD0_BAD0;
  end

  always @(negedge clk) begin
    if (bus_b.mem_ce === 1'b1) begin
      pend_b      = cyc;
      pend_addr_b = bus_b.mem_addr;
      if (bus_b.mem_we) mem_b[bus_b.mem_addr] = bus_b.mem_wdata;
    end
    if (cyc == pend_b + int'(WB))
      bus_b.mem_rdata = mem_b.exists(pend_addr_b) ? mem_b[pend_addr_b] : 32'h0;
    else
      bus_b.mem_rdata = 32'hBAD0_BAD0;
  end

  // Monitors: pop expectations whenever a DUT presents mem_ce or m_ack.
  always @(negedge clk) begin
    if (bus_a.mem_ce === 1'b1) begin
      if (iss_qa.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL iss_a_unexpected at cycle %0d: got addr %h expected no issue", cyc, bus_a.mem_addr);
      end else begin
        ie_a = iss_qa.pop_front();
        check("iss_a_cyc", 64'(cyc), 64'(ie_a.cyc));
        check("iss_a_we", 64'(bus_a.mem_we), 64'(ie_a.we));
        check("iss_a_addr", 64'(bus_a.mem_addr), 64'(ie_a.addr));
        if (ie_a.we) check("iss_a_wdata", 64'(bus_a.mem_wdata), 64'(ie_a.wdata));
      end
    end
    if (bus_a.m_ack !== '0 && bus_a.m_ack !== 'x) begin
      if (ack_qa.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL ack_a_unexpected at cycle %0d: got %b expected none", cyc, bus_a.m_ack);
      end else begin
        ae_a = ack_qa.pop_front();
        check("ack_a_cyc", 64'(cyc), 64'(ae_a.cyc));
        check("ack_a_vec", 64'(bus_a.m_ack), 64'(ae_a.ack));
        check("ack_a_rdata", 64'(bus_a.m_rdata), 64'(ae_a.rdata));
      end
    end
  end

  always @(negedge clk) begin
    if (bus_b.mem_ce === 1'b1) begin
      if (iss_qb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL iss_b_unexpected at cycle %0d: got addr %h expected no issue", cyc, bus_b.mem_addr);
      end else begin
        ie_b = iss_qb.pop_front();
        check("iss_b_cyc", 64'(cyc), 64'(ie_b.cyc));
        check("iss_b_we", 64'(bus_b.mem_we), 64'(ie_b.we));
        check("iss_b_addr", 64'(bus_b.mem_addr), 64'(ie_b.addr));
        if (ie_b.we) check("iss_b_wdata", 64'(bus_b.mem_wdata), 64'(ie_b.wdata));
      end
    end
    if (bus_b.m_ack !== '0 && bus_b.m_ack !== 'x) begin
      if (ack_qb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL ack_b_unexpected at cycle %0d: got %b expected none", cyc, bus_b.m_ack);
      end else begin
        ae_b = ack_qb.pop_front();
        check("ack_b_cyc", 64'(cyc), 64'(ae_b.cyc));
        check("ack_b_vec", 64'(bus_b.m_ack), 64'(ae_b.ack));
        check("ack_b_rdata", 64'(bus_b.m_rdata), 64'(ae_b.rdata));
      end
    end
  end

  task automatic wait_ack_a(input logic [NA-1:0] mask, output logic [NA-1:0] got);
    got = '0;
    for (int k = 0; k < 40 && got == '0; k++) begin
      @(negedge clk);
      got = bus_a.m_ack & mask;
    end
    if (got == '0) begin
      n_checks++; n_fail++;
      $display("FAIL ack_a_timeout: got no ack expected one of %b", mask);
    end
  endtask

  task automatic wait_ack_b(input logic [NB-1:0] mask, output logic [NB-1:0] got);
    got = '0;
    for (int k = 0; k < 40 && got == '0; k++) begin
      @(negedge clk);
      got = bus_b.m_ack & mask;
    end
    if (got == '0) begin
      n_checks++; n_fail++;
      $display("FAIL ack_b_timeout: got no ack expected one of %b", mask);
    end
  endtask

  // One isolated transaction; lat is the hand-computed req-to-ack distance.
  task automatic xact_a(input int idx, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd, input int lat);
    iss_exp_t ie;
    ack_exp_t ae;
    logic [NA-1:0] got;
    int t;
    @(negedge clk);
    t = cyc;
    bus_a.m_addr[idx*AW +: AW]  = addr;
    bus_a.m_wdata[idx*DW +: DW] = wdata;
    bus_a.m_we[idx]  = we;
    bus_a.m_req[idx] = 1'b1;
    ie.cyc = t + 1; ie.we = we; ie.addr = addr; ie.wdata = wdata;
    iss_qa.push_back(ie);
    ae.cyc = t + lat; ae.ack = 8'(32'd1 << idx); ae.rdata = exp_rd;
    ack_qa.push_back(ae);
    wait_ack_a(NA'(32'd1 << idx), got);
    bus_a.m_req[idx] = 1'b0;
  endtask

  task automatic xact_b(input int idx, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd, input int lat);
    iss_exp_t ie;
    ack_exp_t ae;
    logic [NB-1:0] got;
    int t;
    @(negedge clk);
    t = cyc;
    bus_b.m_addr[idx*AW +: AW]  = addr;
    bus_b.m_wdata[idx*DW +: DW] = wdata;
    bus_b.m_we[idx]  = we;
    bus_b.m_req[idx] = 1'b1;
    ie.cyc = t + 1; ie.we = we; ie.addr = addr; ie.wdata = wdata;
    iss_qb.push_back(ie);
    ae.cyc = t + lat; ae.ack = 8'(32'd1 << idx); ae.rdata = exp_rd;
    ack_qb.push_back(ae);
    wait_ack_b(NB'(32'd1 << idx), got);
    bus_b.m_req[idx] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0]   con_addr [5];
    logic [31:0]   con_rd   [5];
    int            con_ack  [5];
    logic [7:0]    con_vec  [5];
    logic [NA-1:0] got_a;
    logic [NB-1:0] got_b;
    bit            m0_again;
    iss_exp_t      ie;
    ack_exp_t      ae;
    int            t;

    con_addr = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110};
    con_rd   = '{32'h1111_0100, 32'h1111_0104, 32'h1111_0108, 32'h1111_010C, 32'h2222_0110};
    con_ack  = '{2, 5, 8, 11, 14};
    con_vec  = '{8'b0001, 8'b0010, 8'b0100, 8'b1000, 8'b0001};
    for (int i = 0; i < 5; i++) mem_a[con_addr[i]] = con_rd[i];
    mem_a[32'h10] = 32'h3401_1100;
    mem_b[32'h40] = 32'h4444_0040;
    mem_b[32'h50] = 32'h5555_0050;
    mem_b[32'h54] = 32'h5555_0054;

    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.m_req = '0; bus_a.m_we = '0; bus_a.m_addr = '0; bus_a.m_wdata = '0;
    bus_b.m_req = '0; bus_b.m_we = '0; bus_b.m_addr = '0; bus_b.m_wdata = '0;
    repeat (3) @(negedge clk);

    check("rst_a_ack", 64'(bus_a.m_ack), 64'(0));
    check("rst_a_rdata", 64'(bus_a.m_rdata), 64'(0));
    check("rst_a_ce_we_busy", 64'({bus_a.mem_ce, bus_a.mem_we, bus_a.busy}), 64'(0));
    check("rst_a_addr", 64'(bus_a.mem_addr), 64'(0));
    check("rst_a_wdata", 64'(bus_a.mem_wdata), 64'(0));
    rst_a = 1'b0;

    // All four masters request together; master 0 stays on with a new address.
    @(negedge clk);
    t = cyc;
    for (int i = 0; i < 4; i++) bus_a.m_addr[i*AW +: AW] = con_addr[i];
    bus_a.m_req = 4'hF;
    for (int i = 0; i < 5; i++) begin
      ie.cyc = t + con_ack[i] - 1; ie.we = 1'b0; ie.addr = con_addr[i]; ie.wdata = '0;
      iss_qa.push_back(ie);
      ae.cyc = t + con_ack[i]; ae.ack = con_vec[i]; ae.rdata = con_rd[i];
      ack_qa.push_back(ae);
    end
    m0_again = 1'b0;
    for (int n = 0; n < 5; n++) begin
      wait_ack_a(4'hF, got_a);
      if (got_a == 4'b0001 && !m0_again) begin
        m0_again = 1'b1;
        bus_a.m_addr[0 +: AW] = con_addr[4];
      end else begin
        bus_a.m_req = bus_a.m_req & ~got_a;
      end
    end
    check("con_a_busy_in_ack", 64'(bus_a.busy), 64'(1));

    xact_a(0, 1'b0, 32'h10, 32'h0,         32'h3401_1100, 2);
    xact_a(1, 1'b1, 32'h20, 32'hDEAD_BEEF, 32'h3401_1100, 2);
    xact_a(1, 1'b0, 32'h20, 32'h0,         32'hDEAD_BEEF, 2);
    @(negedge clk);
    check("a_busy_idle", 64'(bus_a.busy), 64'(0));

    check("rst_b_ack", 64'(bus_b.m_ack), 64'(0));
    check("rst_b_ce_we_busy", 64'({bus_b.mem_ce, bus_b.mem_we, bus_b.busy}), 64'(0));
    rst_b = 1'b0;

    xact_b(1, 1'b0, 32'h40, 32'h0, 32'h4444_0040, 5);

    // Master 0 read aborted by a one-cycle reset while in WAIT.
    @(negedge clk);
    t = cyc;
    bus_b.m_addr[0 +: AW] = 32'h30;
    bus_b.m_req[0] = 1'b1;
    ie.cyc = t + 1; ie.we = 1'b0; ie.addr = 32'h30; ie.wdata = '0;
    iss_qb.push_back(ie);
    repeat (3) @(negedge clk);
    check("abort_b_busy_before", 64'(bus_b.busy), 64'(1));
    rst_b = 1'b1;
    bus_b.m_req = '0;
    @(negedge clk);
    rst_b = 1'b0;
    check("abort_b_ack", 64'(bus_b.m_ack), 64'(0));
    check("abort_b_rdata", 64'(bus_b.m_rdata), 64'(0));
    check("abort_b_ce_we_busy", 64'({bus_b.mem_ce, bus_b.mem_we, bus_b.busy}), 64'(0));
    check("abort_b_addr", 64'(bus_b.mem_addr), 64'(0));
    repeat (8) @(negedge clk);

    // Both request after reset: pointer restarts so master 0 wins first.
    @(negedge clk);
    t = cyc;
    bus_b.m_addr[0 +: AW]  = 32'h50;
    bus_b.m_addr[AW +: AW] = 32'h54;
    bus_b.m_req = 2'b11;
    ie.cyc = t + 1; ie.addr = 32'h50; iss_qb.push_back(ie);
    ie.cyc = t + 7; ie.addr = 32'h54; iss_qb.push_back(ie);
    ae.cyc = t + 5;  ae.ack = 8'b01; ae.rdata = 32'h5555_0050; ack_qb.push_back(ae);
    ae.cyc = t + 11; ae.ack = 8'b10; ae.rdata = 32'h5555_0054; ack_qb.push_back(ae);
    for (int n = 0; n < 2; n++) begin
      wait_ack_b(2'b11, got_b);
      bus_b.m_req = bus_b.m_req & ~got_b;
    end

    repeat (6) @(negedge clk);
    check("end_iss_qa_empty", 64'(iss_qa.size()), 64'(0));
    check("end_ack_qa_empty", 64'(ack_qa.size()), 64'(0));
    check("end_iss_qb_empty", 64'(iss_qb.size()), 64'(0));
    check("end_ack_qb_empty", 64'(ack_qb.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
